// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter
//   Shares one AXI read port between the instruction-fetch (IF) and
//   load/store (MEM) requesters. It arbitrates AR requests round-robin,
//   tags the downstream ID (IF -> 1, MEM -> 0), and returns R beats to
//   the owning requester. Burst end comes from an internal beat counter,
//   so the slave's r_last is never needed. The write channels do not pass
//   through this block.
//
// Handshake rule: every channel transfers on a cycle where valid and ready
//   are both high at the rising clock edge. valid never waits on ready.
//   A requester may drop valid before it is granted without losing anything.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   if_ar_* / mem_ar_*   requester read-address channels (valid/ready/addr/len)
//   if_r_*  / mem_r_*    requester read-data channels (valid/ready/data/last)
//   s_ar_*               downstream read-address channel
//   s_r_*                downstream read-data channel (valid/ready/data)
//   dbg_state_o          FSM state: 0 = IDLE, 1 = ADDR, 2 = DATA
module axi_rd_arbiter #(
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_ID_WIDTH   = 4
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      if_ar_valid,
    output logic                      if_ar_ready,
    input  logic [AXI_ADDR_WIDTH-1:0] if_ar_addr,
    input  logic [7:0]                if_ar_len,
    output logic                      if_r_valid,
    input  logic                      if_r_ready,
    output logic [AXI_DATA_WIDTH-1:0] if_r_data,
    output logic                      if_r_last,

    input  logic                      mem_ar_valid,
    output logic                      mem_ar_ready,
    input  logic [AXI_ADDR_WIDTH-1:0] mem_ar_addr,
    input  logic [7:0]                mem_ar_len,
    output logic                      mem_r_valid,
    input  logic                      mem_r_ready,
    output logic [AXI_DATA_WIDTH-1:0] mem_r_data,
    output logic                      mem_r_last,

    output logic                      s_ar_valid,
    input  logic                      s_ar_ready,
    output logic [AXI_ID_WIDTH-1:0]   s_ar_id,
    output logic [AXI_ADDR_WIDTH-1:0] s_ar_addr,
    output logic [7:0]                s_ar_len,
    output logic [2:0]                s_ar_size,
    output logic [1:0]                s_ar_burst,
    input  logic                      s_r_valid,
    output logic                      s_r_ready,
    input  logic [AXI_DATA_WIDTH-1:0] s_r_data,

    output logic [1:0]                dbg_state_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic                      owner_if_q, owner_if_d;         // 1: IF owns the port
    logic                      last_grant_if_q, last_grant_if_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]                len_q, len_d;
    logic [7:0]                cnt_q, cnt_d;

    logic grant_if;
    logic grant_mem;
    logic owner_r_ready;
    logic beat_fire;
    logic beat_last;

    // Round-robin: on a tie the requester that was not served last wins.
    assign grant_if  = if_ar_valid && (!mem_ar_valid || !last_grant_if_q);
    assign grant_mem = mem_ar_valid && !grant_if;

    assign owner_r_ready = owner_if_q ? if_r_ready : mem_r_ready;
    assign beat_fire     = (state_q == ST_DATA) && s_r_valid && owner_r_ready;
    // Compare before increment, so len=255 ends on cnt=255 with no wrap issue.
    assign beat_last     = (cnt_q == len_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            owner_if_q      <= 1'b1;
            last_grant_if_q <= 1'b0;
            addr_q          <= '0;
            len_q           <= '0;
            cnt_q           <= '0;
        end else begin
            state_q         <= state_d;
            owner_if_q      <= owner_if_d;
            last_grant_if_q <= last_grant_if_d;
            addr_q          <= addr_d;
            len_q           <= len_d;
            cnt_q           <= cnt_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        owner_if_d      = owner_if_q;
        last_grant_if_d = last_grant_if_q;
        addr_d          = addr_q;
        len_d           = len_q;
        cnt_d           = cnt_q;

        if_ar_ready  = 1'b0;
        mem_ar_ready = 1'b0;
        if_r_valid   = 1'b0;
        mem_r_valid  = 1'b0;
        if_r_last    = 1'b0;
        mem_r_last   = 1'b0;
        s_ar_valid   = 1'b0;
        s_r_ready    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if_ar_ready  = grant_if;
                mem_ar_ready = grant_mem;
                if (grant_if || grant_mem) begin
                    state_d    = ST_ADDR;
                    owner_if_d = grant_if;
                    addr_d     = grant_if ? if_ar_addr : mem_ar_addr;
                    len_d      = grant_if ? if_ar_len  : mem_ar_len;
                    cnt_d      = '0;
                end
            end

            ST_ADDR: begin
                s_ar_valid = 1'b1;
                if (s_ar_ready) begin
                    state_d = ST_DATA;
                end
            end

            ST_DATA: begin
                s_r_ready = owner_r_ready;
                if (owner_if_q) begin
                    if_r_valid = s_r_valid;
                    if_r_last  = s_r_valid && beat_last;
                end else begin
                    mem_r_valid = s_r_valid;
                    mem_r_last  = s_r_valid && beat_last;
                end
                if (beat_fire) begin
                    cnt_d = cnt_q + 8'd1;
                    if (beat_last) begin
                        last_grant_if_d = owner_if_q;
                        state_d         = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The ID is only meaningful once a request has been latched; in IDLE
    // (and therefore out of reset) it reads 0.
    assign s_ar_id    = (state_q != ST_IDLE && owner_if_q) ? AXI_ID_WIDTH'(1) : '0;
    assign s_ar_addr  = addr_q;
    assign s_ar_len   = len_q;
    assign s_ar_size  = 3'b011;
    assign s_ar_burst = 2'b01;

    assign if_r_data  = s_r_data;
    assign mem_r_data = s_r_data;

    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter
//   Directed scenarios followed by a randomized phase for axi_rd_arbiter.
//   Inputs change on the falling edge; outputs are sampled 1 ns later.
//   The randomized phase keeps both requesters permanently busy, so the
//   round-robin rule makes the expected grant order a strict IF/MEM
//   alternation. The slave side replays each accepted burst with data
//   derived from the expected address and beat index.
module tb_axi_rd_arbiter;

    localparam int DW = 64;
    localparam int AW = 32;
    localparam int IW = 4;
    localparam int N  = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_ar_valid, if_ar_ready, if_r_valid, if_r_ready, if_r_last;
    logic [AW-1:0] if_ar_addr;
    logic [7:0]    if_ar_len;
    logic [DW-1:0] if_r_data;
    logic          mem_ar_valid, mem_ar_ready, mem_r_valid, mem_r_ready, mem_r_last;
    logic [AW-1:0] mem_ar_addr;
    logic [7:0]    mem_ar_len;
    logic [DW-1:0] mem_r_data;
    logic          s_ar_valid, s_ar_ready, s_r_valid, s_r_ready;
    logic [IW-1:0] s_ar_id;
    logic [AW-1:0] s_ar_addr;
    logic [7:0]    s_ar_len;
    logic [2:0]    s_ar_size;
    logic [1:0]    s_ar_burst;
    logic [DW-1:0] s_r_data;
    logic [1:0]    dbg_state;

    int errors = 0;
    int checks = 0;

    // clock / reset
    always #5 clk = ~clk;

    axi_rd_arbiter #(.AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .AXI_ID_WIDTH(IW)) dut (
        .clk(clk), .rst(rst),
        .if_ar_valid(if_ar_valid), .if_ar_ready(if_ar_ready), .if_ar_addr(if_ar_addr),
        .if_ar_len(if_ar_len), .if_r_valid(if_r_valid), .if_r_ready(if_r_ready),
        .if_r_data(if_r_data), .if_r_last(if_r_last),
        .mem_ar_valid(mem_ar_valid), .mem_ar_ready(mem_ar_ready), .mem_ar_addr(mem_ar_addr),
        .mem_ar_len(mem_ar_len), .mem_r_valid(mem_r_valid), .mem_r_ready(mem_r_ready),
        .mem_r_data(mem_r_data), .mem_r_last(mem_r_last),
        .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_id(s_ar_id),
        .s_ar_addr(s_ar_addr), .s_ar_len(s_ar_len), .s_ar_size(s_ar_size),
        .s_ar_burst(s_ar_burst), .s_r_valid(s_r_valid), .s_r_ready(s_r_ready),
        .s_r_data(s_r_data), .dbg_state_o(dbg_state)
    );

    // scoreboard: expected downstream requests {id_is_if, addr, len}, and grant order
    logic [40:0] exp_ar_q[$];
    logic [0:0]  exp_owner_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] beat_data(input logic [31:0] a, input int b);
        return {a, 24'hc0ffee, 8'(b)};
    endfunction

    // driver tasks
    task automatic clear_inputs();
        if_ar_valid = 1'b0; if_ar_addr = '0; if_ar_len = '0; if_r_ready = 1'b0;
        mem_ar_valid = 1'b0; mem_ar_addr = '0; mem_ar_len = '0; mem_r_ready = 1'b0;
        s_ar_ready = 1'b0; s_r_valid = 1'b0; s_r_data = '0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ar_ready"}, 64'({if_ar_ready, mem_ar_ready}), 64'd0);
        chk({tag, "_r_valid"}, 64'({if_r_valid, mem_r_valid}), 64'd0);
        chk({tag, "_r_last"}, 64'({if_r_last, mem_r_last}), 64'd0);
        chk({tag, "_s_ar_valid"}, 64'(s_ar_valid), 64'd0);
        chk({tag, "_s_r_ready"}, 64'(s_r_ready), 64'd0);
        chk({tag, "_s_ar_addr"}, 64'(s_ar_addr), 64'd0);
        chk({tag, "_s_ar_len"}, 64'(s_ar_len), 64'd0);
        chk({tag, "_s_ar_id"}, 64'(s_ar_id), 64'd0);
        chk({tag, "_state"}, 64'(dbg_state), 64'd0);
    endtask

    // Starts at a falling edge; ends at the next falling edge (reset released).
    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
    endtask

    // Single requester presents a request in IDLE; ends at the next falling edge.
    task automatic request(input bit is_if, input logic [31:0] addr, input logic [7:0] len);
        if (is_if) begin
            if_ar_valid = 1'b1; if_ar_addr = addr; if_ar_len = len;
        end else begin
            mem_ar_valid = 1'b1; mem_ar_addr = addr; mem_ar_len = len;
        end
        #1;
        chk("req_winner_ready", 64'(is_if ? if_ar_ready : mem_ar_ready), 64'd1);
        chk("req_loser_ready", 64'(is_if ? mem_ar_ready : if_ar_ready), 64'd0);
        @(negedge clk);
        if (is_if) if_ar_valid = 1'b0;
        else mem_ar_valid = 1'b0;
    endtask

    // ADDR phase: slave accepts after 'delay' wait cycles; a stray beat is offered throughout.
    task automatic addr_phase(input bit is_if, input logic [31:0] addr, input logic [7:0] len,
                              input int delay);
        s_r_valid = 1'b1; s_r_data = 64'hdead_beef_0bad_f00d;
        if_r_ready = 1'b1; mem_r_ready = 1'b1;
        for (int i = 0; i <= delay; i++) begin
            s_ar_ready = (i == delay);
            #1;
            chk("ar_valid", 64'(s_ar_valid), 64'd1);
            chk("ar_id", 64'(s_ar_id), is_if ? 64'd1 : 64'd0);
            chk("ar_addr", 64'(s_ar_addr), 64'(addr));
            chk("ar_len", 64'(s_ar_len), 64'(len));
            chk("ar_size_burst", 64'({s_ar_size, s_ar_burst}), 64'(5'b011_01));
            chk("ar_ready_held", 64'({if_ar_ready, mem_ar_ready}), 64'd0);
            chk("stray_blocked", 64'({if_r_valid, mem_r_valid, s_r_ready}), 64'd0);
            @(negedge clk);
        end
        s_ar_ready = 1'b0; s_r_valid = 1'b0; if_r_ready = 1'b0; mem_r_ready = 1'b0;
    endtask

    // DATA phase: len+1 beats; before beat stall_beat the owner holds r_ready low
    // for stall_cyc cycles. Ends 1 ns after the falling edge of the cycle after the last beat.
    task automatic data_phase(input bit is_if, input logic [31:0] addr, input logic [7:0] len,
                              input int stall_beat, input int stall_cyc);
        for (int b = 0; b <= int'(len); b++) begin
            s_r_valid = 1'b1;
            s_r_data  = beat_data(addr, b);
            if (b == stall_beat) begin
                for (int s = 0; s < stall_cyc; s++) begin
                    if_r_ready = !is_if; mem_r_ready = is_if;
                    #1;
                    chk("stall_s_r_ready", 64'(s_r_ready), 64'd0);
                    chk("stall_r_valid", 64'(is_if ? if_r_valid : mem_r_valid), 64'd1);
                    @(negedge clk);
                end
            end
            if_r_ready = 1'b1; mem_r_ready = 1'b1;
            #1;
            chk("beat_owner_valid", 64'(is_if ? if_r_valid : mem_r_valid), 64'd1);
            chk("beat_other_valid", 64'(is_if ? mem_r_valid : if_r_valid), 64'd0);
            chk("beat_s_r_ready", 64'(s_r_ready), 64'd1);
            chk("beat_data", is_if ? if_r_data : mem_r_data, beat_data(addr, b));
            chk("beat_last", 64'(is_if ? if_r_last : mem_r_last), 64'(b == int'(len)));
            chk("beat_ar_ready_held", 64'({if_ar_ready, mem_ar_ready}), 64'd0);
            @(negedge clk);
        end
        s_r_valid = 1'b0; if_r_ready = 1'b0; mem_r_ready = 1'b0;
        #1;
        chk("burst_end_idle", 64'(dbg_state), 64'd0);
        chk("burst_end_s_r_ready", 64'(s_r_ready), 64'd0);
    endtask

    initial begin
        int          if_i;
        int          mem_i;
        int          cyc;
        bit          done;
        bit          sl_active;
        bit          was_active;
        logic        sl_if;
        logic [31:0] sl_addr;
        logic [7:0]  sl_len;
        int          sl_beat;
        logic [31:0] if_addr_l[N];
        logic [7:0]  if_len_l[N];
        logic [31:0] mem_addr_l[N];
        logic [7:0]  mem_len_l[N];
        logic [40:0] e;
        logic        own_rr;

        clear_inputs();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk_reset_outputs("por");
        @(negedge clk);

        // Single IF request, len 0.
        request(1'b1, 32'h8000_0000, 8'd0);
        addr_phase(1'b1, 32'h8000_0000, 8'd0, 0);
        data_phase(1'b1, 32'h8000_0000, 8'd0, -1, 0);
        @(negedge clk);

        // Stray downstream beat while idle.
        s_r_valid = 1'b1; if_r_ready = 1'b1; mem_r_ready = 1'b1;
        #1;
        chk("idle_stray", 64'({if_r_valid, mem_r_valid, s_r_ready}), 64'd0);
        @(negedge clk);
        clear_inputs();

        // Simultaneous requests after reset: strict alternation starting with IF.
        do_reset();
        if_ar_valid = 1'b1; if_ar_addr = 32'h8000_0100; if_ar_len = 8'd0;
        mem_ar_valid = 1'b1; mem_ar_addr = 32'h8000_0200; mem_ar_len = 8'd0;
        for (int k = 0; k < 4; k++) begin
            bit w_if;
            w_if = (k % 2 == 0);
            #1;
            chk("rr_grant", 64'({if_ar_ready, mem_ar_ready}), w_if ? 64'd2 : 64'd1);
            @(negedge clk);
            if (w_if) if_ar_valid = 1'b0;
            else mem_ar_valid = 1'b0;
            addr_phase(w_if, w_if ? 32'h8000_0100 : 32'h8000_0200, 8'd0, 0);
            data_phase(w_if, w_if ? 32'h8000_0100 : 32'h8000_0200, 8'd0, -1, 0);
            if (w_if) if_ar_valid = 1'b1;
            else mem_ar_valid = 1'b1;
        end
        if_ar_valid = 1'b0; mem_ar_valid = 1'b0;
        @(negedge clk);

        // MEM len 3 with IF waiting; IF accepted the cycle after the final beat.
        request(1'b0, 32'h8000_1000, 8'd3);
        addr_phase(1'b0, 32'h8000_1000, 8'd3, 0);
        if_ar_valid = 1'b1; if_ar_addr = 32'h8000_1800; if_ar_len = 8'd1;
        data_phase(1'b0, 32'h8000_1000, 8'd3, -1, 0);
        chk("if_accepted_after_burst", 64'(if_ar_ready), 64'd1);
        @(negedge clk);
        if_ar_valid = 1'b0;
        addr_phase(1'b1, 32'h8000_1800, 8'd1, 0);
        data_phase(1'b1, 32'h8000_1800, 8'd1, -1, 0);
        @(negedge clk);

        // Delayed s_ar_ready and owner backpressure on the last beat of len 2.
        request(1'b0, 32'h8000_2000, 8'd2);
        addr_phase(1'b0, 32'h8000_2000, 8'd2, 5);
        data_phase(1'b0, 32'h8000_2000, 8'd2, 2, 3);
        @(negedge clk);

        // Longest burst: 256 beats.
        request(1'b0, 32'h8000_5000, 8'd255);
        addr_phase(1'b0, 32'h8000_5000, 8'd255, 1);
        data_phase(1'b0, 32'h8000_5000, 8'd255, 100, 2);
        @(negedge clk);

        // Reset on beat 1 of a len-7 burst.
        request(1'b1, 32'h8000_3000, 8'd7);
        addr_phase(1'b1, 32'h8000_3000, 8'd7, 0);
        s_r_valid = 1'b1; s_r_data = beat_data(32'h8000_3000, 0); if_r_ready = 1'b1;
        #1;
        chk("pre_rst_beat0_last", 64'({if_r_valid, if_r_last}), 64'd2);
        @(negedge clk);
        s_r_data = beat_data(32'h8000_3000, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mem_r_ready = 1'b1;
        #1;
        chk_reset_outputs("mid_rst");
        @(negedge clk);
        clear_inputs();
        // Both valid right after reset: IF wins; MEM then withdraws before being granted.
        if_ar_valid = 1'b1; if_ar_addr = 32'h8000_4000; if_ar_len = 8'd1;
        mem_ar_valid = 1'b1; mem_ar_addr = 32'h8000_4400; mem_ar_len = 8'd0;
        #1;
        chk("post_rst_grant", 64'({if_ar_ready, mem_ar_ready}), 64'd2);
        @(negedge clk);
        if_ar_valid = 1'b0; mem_ar_valid = 1'b0;
        addr_phase(1'b1, 32'h8000_4000, 8'd1, 2);
        data_phase(1'b1, 32'h8000_4000, 8'd1, 0, 1);
        @(negedge clk);

        // Randomized phase.
        do_reset();
        for (int k = 0; k < N; k++) begin
            if_addr_l[k]  = 32'h8000_0000 | ($urandom_range(0, 4095) << 3);
            if_len_l[k]   = 8'($urandom_range(0, 7));
            mem_addr_l[k] = 32'h8001_0000 | ($urandom_range(0, 4095) << 3);
            mem_len_l[k]  = 8'($urandom_range(0, 7));
            exp_owner_q.push_back(1'b1);
            exp_owner_q.push_back(1'b0);
        end
        if_i = 0; mem_i = 0; cyc = 0; done = 1'b0;
        sl_active = 1'b0; sl_if = 1'b0; sl_addr = '0; sl_len = '0; sl_beat = 0;
        while (!done && cyc < 20000) begin
            if_ar_valid  = (if_i < N);
            if_ar_addr   = (if_i < N) ? if_addr_l[if_i] : '0;
            if_ar_len    = (if_i < N) ? if_len_l[if_i] : '0;
            mem_ar_valid = (mem_i < N);
            mem_ar_addr  = (mem_i < N) ? mem_addr_l[mem_i] : '0;
            mem_ar_len   = (mem_i < N) ? mem_len_l[mem_i] : '0;
            s_ar_ready   = 1'($urandom_range(0, 1));
            s_r_valid    = sl_active ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 3) == 0);
            s_r_data     = sl_active ? beat_data(sl_addr, sl_beat) : {$urandom, $urandom};
            if_r_ready   = 1'($urandom_range(0, 1));
            mem_r_ready  = 1'($urandom_range(0, 1));
            #1;
            was_active = sl_active;
            if ((if_ar_valid && if_ar_ready) || (mem_ar_valid && mem_ar_ready)) begin
                chk("rnd_grant_pending", 64'(exp_owner_q.size() != 0), 64'd1);
                if (exp_owner_q.size() != 0) begin
                    logic [0:0] w;
                    w = exp_owner_q.pop_front();
                    chk("rnd_grant", 64'({if_ar_ready, mem_ar_ready}), w[0] ? 64'd2 : 64'd1);
                    if (w[0]) begin
                        exp_ar_q.push_back({1'b1, if_addr_l[if_i], if_len_l[if_i]});
                        if_i++;
                    end else begin
                        exp_ar_q.push_back({1'b0, mem_addr_l[mem_i], mem_len_l[mem_i]});
                        mem_i++;
                    end
                end
            end
            if (s_ar_valid && s_ar_ready) begin
                chk("rnd_ar_expected", 64'({exp_ar_q.size() != 0, was_active}), 64'd2);
                if (exp_ar_q.size() != 0) begin
                    e = exp_ar_q.pop_front();
                    chk("rnd_ar_id", 64'(s_ar_id), 64'(e[40]));
                    chk("rnd_ar_addr", 64'(s_ar_addr), 64'(e[39:8]));
                    chk("rnd_ar_len", 64'(s_ar_len), 64'(e[7:0]));
                    sl_active = 1'b1; sl_if = e[40]; sl_addr = e[39:8]; sl_len = e[7:0]; sl_beat = 0;
                end
            end
            if (was_active) begin
                own_rr = sl_if ? if_r_ready : mem_r_ready;
                chk("rnd_s_r_ready", 64'(s_r_ready), 64'(own_rr));
                chk("rnd_owner_valid", 64'(sl_if ? if_r_valid : mem_r_valid), 64'(s_r_valid));
                chk("rnd_other_valid", 64'(sl_if ? mem_r_valid : if_r_valid), 64'd0);
                if (s_r_valid && own_rr) begin
                    chk("rnd_data", sl_if ? if_r_data : mem_r_data, beat_data(sl_addr, sl_beat));
                    chk("rnd_last", 64'(sl_if ? if_r_last : mem_r_last), 64'(sl_beat == int'(sl_len)));
                    sl_beat++;
                    if (sl_beat > int'(sl_len)) sl_active = 1'b0;
                end
            end else begin
                chk("rnd_no_forward", 64'({if_r_valid, mem_r_valid, s_r_ready}), 64'd0);
            end
            done = (if_i == N) && (mem_i == N) && !sl_active && (exp_ar_q.size() == 0);
            cyc++;
            @(negedge clk);
        end
        chk("rnd_complete", 64'(done), 64'd1);
        clear_inputs();

        // final report
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Shares the single AXI read port of the memory slave between two requesters: instruction fetch (IF) and load/store (MEM).
- Owns AR arbitration, tags the downstream ID (the slave selects the instruction path on ID 1), and routes R beats back to the owner.
- Counts beats itself, so burst end never depends on the slave's r_last.
- The write channels bypass this block and connect MEM to the slave directly.

Parameters:
AXI_DATA_WIDTH, 64, R data width
AXI_ADDR_WIDTH, 32, AR address width
AXI_ID_WIDTH, 4, downstream ID width

Ports:
clk  in  1  clock
rst  in  1  reset: synchronous, active-high
if_ar_valid / mem_ar_valid  in  1  read request valid
if_ar_ready / mem_ar_ready  out  1  read request accepted
if_ar_addr / mem_ar_addr  in  AXI_ADDR_WIDTH  8-byte-aligned start address
if_ar_len / mem_ar_len  in  8  beats minus 1
if_r_valid / mem_r_valid  out  1  beat valid to owner
if_r_ready / mem_r_ready  in  1  owner accepts beat
if_r_data / mem_r_data  out  AXI_DATA_WIDTH  beat data (shared copy of s_r_data)
if_r_last / mem_r_last  out  1  final beat, generated from the internal counter
s_ar_valid  out  1  downstream request valid
s_ar_ready  in  1  downstream request accepted
s_ar_id  out  AXI_ID_WIDTH  IF→1, MEM→0
s_ar_addr  out  AXI_ADDR_WIDTH  latched address
s_ar_len  out  8  latched length
s_ar_size  out  3  constant 3'b011
s_ar_burst  out  2  constant 2'b01 (INCR)
s_r_valid  in  1  downstream beat valid
s_r_ready  out  1  downstream beat accept
s_r_data  in  AXI_DATA_WIDTH  downstream beat data

Behaviour:
- States: IDLE, ADDR, DATA. Registers: owner (IF/MEM), last_grant, addr, len, beat counter cnt[7:0].
- Reset (and rst asserted in any state, mid-burst included): state=IDLE; cnt=0; owner=IF; last_grant=MEM, so IF wins the first tie.
- Reset outputs: all ar_ready/r_valid/r_last=0, s_ar_valid=0, s_r_ready=0, s_ar_addr/len/id=0. Any in-flight burst is abandoned and no beat is forwarded.
- IDLE, winner selection (combinational):
  - Only one valid: that requester wins.
  - Both valid: the requester that is not last_grant wins (round-robin).
- IDLE, accept: winner's ar_ready=1 combinationally; loser's ar_ready=0. On winner handshake, latch addr/len/owner, clear cnt, go to ADDR.
- No valid in IDLE: stay in IDLE, all ar_ready=0.
- ADDR: s_ar_valid=1, with s_ar_addr/len/id driven from the latched registers. On s_ar_ready go to DATA. Requester ar_ready=0.
- DATA routing:
  - Owner's r_valid=s_r_valid; s_r_ready=owner's r_ready.
  - Non-owner r_valid=0.
  - r_data is fanned out to both masters.
- DATA, each s_r_valid&s_r_ready:
  - cnt<=cnt+1.
  - Owner r_last=1 when cnt==len.
  - On the beat with cnt==len: last_grant<=owner, go to IDLE.
- The downstream r_last is not used; the counter governs burst end.
- Latency: request handshake at cycle T; s_ar_valid first high at T+1. After a final beat at cycle N, the next request is accepted at N+1 (in IDLE).
- Outside DATA: s_r_ready=0 and both r_valid=0. Stray s_r_valid is held off and never forwarded.
- A requester deasserting valid before being granted is legal and loses nothing.
- Requests arriving during ADDR/DATA wait, with ar_ready held 0.
- len=255: cnt covers 0..255 without wrap ambiguity; the terminal compare happens before increment.
- Backpressure: owner r_ready=0 holds s_r_ready=0; the beat stays pending and cnt is unchanged.

Test Plan:
- Single IF request, addr 0x80000000, len 0 → s_ar_id=1, s_ar_valid at T+1, one beat with if_r_last=1, back to IDLE; mem_r_valid never high.
- IF and MEM valid in the same cycle after reset → IF granted first. Both reassert immediately → MEM granted next, then IF: strict alternation across 4 requests.
- MEM burst len 3 (addr 0x80001000), IF asserts request mid-burst → if_ar_ready stays 0 until mem_r_last on the 4th beat; IF accepted the following cycle.
- s_ar_ready delayed 5 cycles, and mem_r_ready low for 3 cycles on beat 2 of a len-2 burst → s_ar_valid and addr held stable; s_r_ready low during the stall; beat count ends exactly at 3.
- Slave never asserts r_last → arbiter still terminates after len+1 beats.
- rst asserted on beat 1 of a len-7 burst → next cycle all outputs are at reset values, state IDLE; a new IF request is accepted normally.
